// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port RAM.
// One access in flight: IDLE latches the winning request, ACCESS drives the
// RAM strobes for one cycle, RESP pulses the winner's ack for one cycle.
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // port A
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  // port B
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  // RAM side
  output logic              MemWrite,
  output logic              MemRead,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] MemData_out,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            r_state;
  logic              r_id;        // winner of the access in flight: 0 = A, 1 = B
  logic              r_last;      // last-served port: 0 = A, 1 = B
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_mem_write;
  logic              r_mem_read;
  logic              r_a_ack;
  logic              r_b_ack;
  logic [DATA_W-1:0] r_a_rdata;
  logic [DATA_W-1:0] r_b_rdata;
  logic              r_busy;

  logic              w_grant_b;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Round-robin pick: B wins when alone, or on a tie when A was served last.
  always_comb begin
    w_grant_b = b_req & (~a_req | ~r_last);
    w_we      = w_grant_b ? b_we    : a_we;
    w_addr    = w_grant_b ? b_addr  : a_addr;
    w_wdata   = w_grant_b ? b_wdata : a_wdata;
  end

  // Arbitration FSM with registered RAM strobes, acks and read-data holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (a_req || b_req) begin
            r_id        <= w_grant_b;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_mem_write <= w_we;
            r_mem_read  <= ~w_we;
            r_busy      <= 1'b1;
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          r_mem_write <= 1'b0;
          r_mem_read  <= 1'b0;
          // r_mem_read doubles as the latched "this is a read" flag
          if (r_mem_read) begin
            if (r_id) r_b_rdata <= MemData_out;
            else      r_a_rdata <= MemData_out;
          end
          if (r_id) r_b_ack <= 1'b1;
          else      r_a_ack <= 1'b1;
          r_state <= RESP;
        end
        RESP: begin
          r_a_ack <= 1'b0;
          r_b_ack <= 1'b0;
          r_last  <= r_id;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign MemWrite  = r_mem_write;
  assign MemRead   = r_mem_read;
  assign Address   = r_addr;
  assign WriteData = r_wdata;
  assign a_ack     = r_a_ack;
  assign b_ack     = r_b_ack;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign busy      = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a transaction-level reference model predicts each
// grant (round robin on sampled request levels, one access per three edges)
// and pushes it to a scoreboard; a negedge monitor pops and checks strobes,
// acks and read data. Directed scenarios run first, then random traffic.
module tb_ram_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [DW-1:0] a_rdata, b_rdata;
  logic          MemWrite, MemRead, busy;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] MemData_out;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .MemWrite(MemWrite), .MemRead(MemRead), .Address(Address),
    .WriteData(WriteData), .MemData_out(MemData_out), .busy(busy)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int unsigned i);
    logic [DW-1:0] v;
    v = DW'(i * 37 + 11);
    return v ^ 8'hA5;
  endfunction

  // RAM device: preloaded contents, synchronous write, combinational read
  logic [DW-1:0] ram [16];
  assign MemData_out = ram[Address];
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (MemWrite) ram[Address] <= WriteData;
    end
  end

  // Reference model and scoreboard
  typedef struct {
    logic          port;   // 0 = A, 1 = B
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int unsigned   acc_e;  // edge count at which ACCESS begins
  } txn_t;

  txn_t          sb[$];
  txn_t          pend;
  logic [DW-1:0] mmem [16];
  logic [DW-1:0] exp_rd [2];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_last;
  int unsigned   edge_n = 0, free_e = 0, g_e = 0, pend_e = 0;
  bit            g_v = 0, pend_v = 0;

  initial begin
    txn_t t;
    logic win;
    for (int i = 0; i < 16; i++) mmem[i] = init_val(i);
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        sb.delete();
        m_last = 1'b1; free_e = 0; pend_v = 0; g_v = 0;
        exp_rd[0] = '0; exp_rd[1] = '0; m_addr = '0; m_wdata = '0;
      end else begin
        edge_n++;
        if (pend_v && edge_n == pend_e) begin
          pend_v = 0;
          if (pend.we) mmem[pend.addr] = pend.wdata;
          else         exp_rd[pend.port] = mmem[pend.addr];
        end
        if (edge_n >= free_e && (a_req || b_req)) begin
          if (a_req && b_req) win = ~m_last;
          else                win = b_req;
          t.port  = win;
          t.we    = win ? b_we    : a_we;
          t.addr  = win ? b_addr  : a_addr;
          t.wdata = win ? b_wdata : a_wdata;
          t.rdata = mmem[t.addr];
          t.acc_e = edge_n;
          sb.push_back(t);
          pend = t; pend_v = 1; pend_e = edge_n + 1;
          free_e = edge_n + 3; g_e = edge_n; g_v = 1; m_last = win;
          m_addr = t.addr; m_wdata = t.wdata;
        end
      end
    end
  end

  // Monitor: compares every cycle against the model, pops on ack
  initial begin
    txn_t t;
    logic acc_exp, ack_exp, busy_exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_exp = g_v && (edge_n - g_e <= 1);
        chk("busy", 32'(busy), 32'(busy_exp));
        chk("rd_wr_exclusive", 32'(MemWrite & MemRead), 32'd0);
        chk("Address", 32'(Address), 32'(m_addr));
        chk("WriteData", 32'(WriteData), 32'(m_wdata));
        acc_exp = sb.size() > 0 && sb[0].acc_e == edge_n;
        chk("access_strobe", 32'(MemWrite | MemRead), 32'(acc_exp));
        if (acc_exp) chk("MemWrite", 32'(MemWrite), 32'(sb[0].we));
        ack_exp = sb.size() > 0 && sb[0].acc_e + 1 == edge_n;
        if (ack_exp) begin
          t = sb.pop_front();
          chk("ack_pair", 32'({a_ack, b_ack}), t.port ? 32'd1 : 32'd2);
          chk("a_rdata", 32'(a_rdata), 32'(exp_rd[0]));
          chk("b_rdata", 32'(b_rdata), 32'(exp_rd[1]));
          if (!t.we) chk("rd_value", 32'(t.port ? b_rdata : a_rdata), 32'(t.rdata));
        end else begin
          chk("ack_idle", 32'({a_ack, b_ack}), 32'd0);
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_MemWrite"},  32'(MemWrite),  32'd0);
    chk({tag, "_MemRead"},   32'(MemRead),   32'd0);
    chk({tag, "_Address"},   32'(Address),   32'd0);
    chk({tag, "_WriteData"}, 32'(WriteData), 32'd0);
    chk({tag, "_acks"},      32'({a_ack, b_ack}), 32'd0);
    chk({tag, "_a_rdata"},   32'(a_rdata),   32'd0);
    chk({tag, "_b_rdata"},   32'(b_rdata),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  // Stimulus
  initial begin
    int unsigned n, extra;
    logic        ack_port [4];
    int unsigned ack_e [4];

    reset = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

    // asynchronous reset before any clock edge
    #2 reset = 1'b1;
    #1 chk_reset_outputs("por");
    @(negedge clk); @(negedge clk); reset = 1'b0;

    // idle stretch; monitor checks strobes/acks/busy each cycle
    repeat (20) @(negedge clk);

    // A-only write of 0x5A to address 3
    a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'h5A;
    @(negedge clk);
    chk("w_MemWrite", 32'(MemWrite), 32'd1);
    chk("w_Address", 32'(Address), 32'd3);
    chk("w_WriteData", 32'(WriteData), 32'h5A);
    chk("w_b_ack", 32'(b_ack), 32'd0);
    @(negedge clk);
    chk("w_a_ack", 32'(a_ack), 32'd1);
    chk("w_b_ack2", 32'(b_ack), 32'd0);
    a_req = 0;
    @(negedge clk);

    // B-only read of address 3
    b_req = 1; b_we = 0; b_addr = 4'd3;
    @(negedge clk);
    chk("r_MemRead", 32'(MemRead), 32'd1);
    @(negedge clk);
    chk("r_b_ack", 32'(b_ack), 32'd1);
    chk("r_b_rdata", 32'(b_rdata), 32'h5A);
    chk("r_a_rdata", 32'(a_rdata), 32'd0);
    b_req = 0;
    @(negedge clk);

    // tie after reset: A wins first, then alternation every 3 cycles
    #2 reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    a_req = 1; a_we = 0; a_addr = 4'd3;
    b_req = 1; b_we = 0; b_addr = 4'd5;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        ack_port[n] = b_ack; ack_e[n] = edge_n; n++;
      end
    end
    a_req = 0; b_req = 0;
    chk("tie_ack_count", 32'(n), 32'd4);
    if (n == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("tie_order", 32'(ack_port[i]), 32'(i % 2));
        if (i > 0) chk("tie_spacing", ack_e[i] - ack_e[i-1], 32'd3);
      end
    end
    @(negedge clk);

    // reset during the ACCESS cycle of a write of 0xFF to address 7
    a_req = 1; a_we = 1; a_addr = 4'd7; a_wdata = 8'hFF;
    @(negedge clk);
    chk("rst_pre_MemWrite", 32'(MemWrite), 32'd1);
    #1 reset = 1'b1;
    #1 chk("rst_MemWrite", 32'(MemWrite), 32'd0);
    chk("rst_a_ack", 32'(a_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    a_req = 0;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("rst_no_ack", 32'(a_ack), 32'd0);
    b_req = 1; b_we = 0; b_addr = 4'd7;
    @(negedge clk); @(negedge clk);
    chk("rst_rd_ack", 32'(b_ack), 32'd1);
    chk("rst_rd_prior", 32'(b_rdata), 32'(init_val(7)));
    b_req = 0;
    @(negedge clk);

    // one-cycle request pulse still completes exactly once
    a_req = 1; a_we = 0; a_addr = 4'd3;
    @(negedge clk);
    a_req = 0;
    chk("drop_MemRead", 32'(MemRead), 32'd1);
    @(negedge clk);
    chk("drop_a_ack", 32'(a_ack), 32'd1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack || MemRead || MemWrite) extra++;
    end
    chk("drop_no_second", 32'(extra), 32'd0);

    // random traffic
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      if ($urandom_range(0, 249) == 0) begin
        #2 reset = 1'b1;
        a_req = 0; b_req = 0;
        #1 chk("rnd_rst_busy", 32'(busy), 32'd0);
        chk("rnd_rst_MemWrite", 32'(MemWrite), 32'd0);
        @(negedge clk); reset = 1'b0;
        continue;
      end
      if (a_ack) a_req = ($urandom_range(0, 3) == 0);
      else if (!a_req) begin
        a_we = 1'($urandom_range(0, 1)); a_addr = AW'($urandom); a_wdata = DW'($urandom);
        a_req = ($urandom_range(0, 2) == 0);
      end else if ($urandom_range(0, 15) == 0) a_req = 0;
      if (b_ack) b_req = ($urandom_range(0, 3) == 0);
      else if (!b_req) begin
        b_we = 1'($urandom_range(0, 1)); b_addr = AW'($urandom); b_wdata = DW'($urandom);
        b_req = ($urandom_range(0, 2) == 0);
      end else if ($urandom_range(0, 15) == 0) b_req = 0;
    end
    a_req = 0; b_req = 0;
    repeat (8) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 ADDR_W, default 4, RAM address width (16 locations).
REQ-002 DATA_W, default 8, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_req  input  1  port A access request; level, held until a_ack.
REQ-006 a_we  input  1  port A: 1 = write, 0 = read; sampled with a_req.
REQ-007 a_addr  input  ADDR_W  port A address.
REQ-008 a_wdata  input  DATA_W  port A write data.
REQ-009 a_ack  output  1  port A completion pulse, one cycle.
REQ-010 a_rdata  output  DATA_W  port A read data; valid while a_ack=1, held until the next port A read completes.
REQ-011 b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same directions, widths and meanings as the port A signals, for port B.
REQ-012 MemWrite  output  1  RAM write enable.
REQ-013 MemRead  output  1  RAM read enable.
REQ-014 Address  output  ADDR_W  RAM address.
REQ-015 WriteData  output  DATA_W  RAM write data.
REQ-016 MemData_out  input  DATA_W  RAM combinational read data.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP; exactly one access in flight.
REQ-019 IDLE: when any req is high at a clock edge, latch the winner's id, we, addr and wdata, then enter ACCESS; with no req, remain in IDLE.
REQ-020 Arbitration is round-robin:
- With one requester, that requester wins.
- With both requesting, the port not served last wins.
- The last-served pointer resets to B, so A wins the first tie.
REQ-021 ACCESS lasts exactly one cycle.
- Address and WriteData equal the latched values.
- MemWrite equals latched we; MemRead equals the inverse of latched we.
- Next state is RESP.
REQ-022 On a read, MemData_out is captured into the winner's rdata register at the ACCESS-to-RESP edge.
REQ-023 RESP lasts exactly one cycle.
- The winner's ack is 1 and the other ack is 0.
- The last-served pointer updates to the winner.
- Next state is IDLE.
REQ-024 Latency: req sampled at edge N in IDLE; ACCESS occupies cycle N+1; ack=1 in cycle N+2.
- Port throughput is one access per 3 cycles.
- Back-to-back alternating grants occur under continuous contention.
REQ-025 MemWrite and MemRead are 0 in IDLE and RESP and are never both 1.
REQ-026 Address and WriteData hold their last latched values outside ACCESS.
REQ-027 A requester dropping req after being latched does not cancel the access; the access completes and ack still pulses.
REQ-028 A requester holding req high in the cycle after its ack is treated as a new request.
REQ-029 Requests arriving while busy=1 are ignored until the next IDLE cycle.
REQ-030 Inputs of the non-winning port are ignored while busy=1.

Reset
REQ-031 Asserting reset (asynchronous, active-high) immediately forces the following, with no clock edge required:
- State = IDLE.
- MemWrite = 0, MemRead = 0.
- Address = 0, WriteData = 0.
- a_ack = 0, b_ack = 0.
- a_rdata = 0, b_rdata = 0.
- busy = 0.
- Last-served pointer = B.
REQ-032 Reset asserted during ACCESS aborts the access.
- MemWrite falls before the next edge, so no RAM write occurs.
- No ack is issued for the aborted access.
REQ-033 After reset deasserts, the first edge with a req pending is treated as in IDLE.

Verification
REQ-034 A-only write: a_req=1, a_we=1, a_addr=3, a_wdata=0x5A.
- Next cycle: MemWrite=1, Address=3, WriteData=0x5A.
- Following cycle: a_ack=1.
- b_ack stays 0 throughout.
REQ-035 B-only read after the REQ-034 write: b_we=0, b_addr=3.
- ACCESS cycle: MemRead=1.
- RESP cycle: b_ack=1, b_rdata=0x5A.
- a_rdata is unchanged.
REQ-036 Tie after reset: a_req=b_req=1 held continuously, each dropped one cycle after its own ack.
- Ack order: A, B, A, B.
- Acks are 3 cycles apart.
REQ-037 Reset mid-write: assert reset during ACCESS of a write of 0xFF to address 7.
- MemWrite=0 immediately; no ack is issued.
- A subsequent read of address 7 returns the RAM's prior value.
REQ-038 Early drop: a_req pulsed for one cycle only.
- The access completes and a_ack pulses once, in cycle N+2.
- No second access follows.
REQ-039 Idle check: no requests for 20 cycles after reset.
- busy=0 throughout.
- MemWrite=0 and MemRead=0 throughout.
- All acks remain 0.
